// File: rtl/wm_pkg.sv
// Shared encodings for the washing-machine phase timer: wash programs,
// timed phases, supervisor states and the fixed duration table.
package wm_pkg;

    typedef enum logic [1:0] {
        PROG_QUICK  = 2'd0,
        PROG_NORMAL = 2'd1,
        PROG_HEAVY  = 2'd2,
        PROG_CUSTOM = 2'd3
    } prog_e;

    typedef enum logic [1:0] {
        PH_WASH  = 2'd0,
        PH_RINSE = 2'd1,
        PH_SPIN  = 2'd2
    } phase_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN_WASH  = 3'd1,
        RUN_RINSE = 3'd2,
        RUN_SPIN  = 3'd3,
        EXPIRE    = 3'd4,
        FAULT     = 3'd5
    } state_e;

    // Phase durations in ticks, indexed [program][phase] (wash, rinse, spin).
    // The custom row is never read; custom durations come from the ports.
    localparam int unsigned DUR_TBL [4][3] = '{
        '{ 60, 30, 20},
        '{120, 60, 40},
        '{240, 90, 60},
        '{  0,  0,  0}
    };

endpackage

// File: rtl/iiitb_wm_timer_if.sv
// Signals exchanged between the washing-machine control FSM (master) and
// the phase timer (slave): actuator outputs in, timeouts back.
interface iiitb_wm_timer_if;

    logic door_lock;
    logic motor_on;
    logic fill_value_on;
    logic drain_value_on;
    logic water_wash;
    logic done;
    logic cycle_timeout;
    logic spin_timeout;

    modport master (
        output door_lock, motor_on, fill_value_on, drain_value_on, water_wash, done,
        input  cycle_timeout, spin_timeout
    );

    modport slave (
        input  door_lock, motor_on, fill_value_on, drain_value_on, water_wash, done,
        output cycle_timeout, spin_timeout
    );

endinterface

// File: rtl/wm_tick_prescaler.sv
// Divides clk down to a single-cycle tick every TICK_DIV cycles.
// clear restarts the count from 0; hold freezes it and suppresses tick.
module wm_tick_prescaler #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int unsigned     PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] count;

    // Free-running modulo-TICK_DIV counter with restart and freeze.
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (!hold) begin
            count <= (count == LAST) ? '0 : count + PW'(1);
        end
    end

    assign tick = !hold && (count == LAST);

endmodule

// File: rtl/iiitb_wm_timer.sv
// Phase timer and supervisor for the washing-machine FSM. Infers the running
// phase from the actuator outputs, times it in prescaled ticks, returns
// registered cycle/spin timeouts and runs a sticky fill watchdog.
module iiitb_wm_timer
    import wm_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 1000,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned FILL_WD_TICKS = 300
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       prog_sel,
    input  logic [CNT_W-1:0] custom_wash,
    input  logic [CNT_W-1:0] custom_spin,
    input  logic             pause,
    iiitb_wm_timer_if.slave  fsm,
    output logic             fault,
    output logic             busy,
    output logic [CNT_W-1:0] remaining
);

    localparam int unsigned WD_W = $clog2(FILL_WD_TICKS + 1);

    state_e           state, state_nxt;
    phase_e           phase_q, phase_nxt;
    prog_e            prog_q;
    logic [CNT_W-1:0] cwash_q, cspin_q;
    logic             door_q;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             cto_q, sto_q, cto_nxt, sto_nxt;
    logic [WD_W-1:0]  wd_cnt;
    logic             tick, presc_clear, wd_fire, phase_req;

    function automatic logic is_run(input state_e s);
        return (s == RUN_WASH) || (s == RUN_RINSE) || (s == RUN_SPIN);
    endfunction

    // Duration of a phase for the latched program; zero is promoted to one tick.
    function automatic logic [CNT_W-1:0] duration(input prog_e p, input phase_e ph,
                                                   input logic [CNT_W-1:0] cw,
                                                   input logic [CNT_W-1:0] cs);
        logic [CNT_W-1:0] d;
        if (p == PROG_CUSTOM) begin
            case (ph)
                PH_WASH:  d = cw;
                PH_RINSE: d = cw >> 1;
                default:  d = cs;
            endcase
        end else begin
            d = CNT_W'(DUR_TBL[p][ph]);
        end
        return (d == '0) ? CNT_W'(1) : d;
    endfunction

    wm_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (presc_clear),
        .hold  (pause),
        .tick  (tick)
    );

    // The tick phase restarts whenever a timed phase begins or the block idles.
    assign presc_clear = (state_nxt != state) && ((state_nxt == IDLE) || is_run(state_nxt));
    assign phase_req   = (phase_q == PH_SPIN) ? fsm.drain_value_on : fsm.motor_on;
    assign wd_fire     = fsm.fill_value_on && tick && (wd_cnt == WD_W'(FILL_WD_TICKS - 1));

    // Capture the program on the door-lock rising edge; completion reverts to quick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            door_q  <= 1'b0;
            prog_q  <= PROG_QUICK;
            cwash_q <= '0;
            cspin_q <= '0;
        end else begin
            door_q <= fsm.door_lock;
            if (fsm.done) begin
                prog_q <= PROG_QUICK;
            end else if (fsm.door_lock && !door_q) begin
                prog_q  <= prog_e'(prog_sel);
                cwash_q <= custom_wash;
                cspin_q <= custom_spin;
            end
        end
    end

    // Count consecutive fill ticks; saturates so the fault cannot re-arm by wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if (!fsm.fill_value_on) begin
            wd_cnt <= '0;
        end else if (tick && (wd_cnt != WD_W'(FILL_WD_TICKS))) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    // Supervisor next-state, counter and timeout decode.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        phase_nxt = phase_q;
        cnt_nxt   = cnt_q;
        cto_nxt   = 1'b0;
        sto_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (!fsm.done) begin
                    if (fsm.motor_on) begin
                        phase_nxt = fsm.water_wash ? PH_RINSE : PH_WASH;
                        state_nxt = fsm.water_wash ? RUN_RINSE : RUN_WASH;
                        cnt_nxt   = duration(prog_q, phase_nxt, cwash_q, cspin_q);
                    end else if (fsm.drain_value_on) begin
                        phase_nxt = PH_SPIN;
                        state_nxt = RUN_SPIN;
                        cnt_nxt   = duration(prog_q, PH_SPIN, cwash_q, cspin_q);
                    end
                end
            end
            RUN_WASH, RUN_RINSE, RUN_SPIN: begin
                // A dropped request or open door abandons the phase silently.
                if (fsm.done || !fsm.door_lock || !phase_req) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_nxt = EXPIRE;
                    end
                end
            end
            EXPIRE: begin
                if (fsm.done || !phase_req) begin
                    state_nxt = IDLE;
                end else begin
                    cto_nxt = (phase_q != PH_SPIN);
                    sto_nxt = (phase_q == PH_SPIN);
                end
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
        if (wd_fire) begin
            state_nxt = FAULT;
            cto_nxt   = 1'b0;
            sto_nxt   = 1'b0;
        end
        if (!is_run(state_nxt)) begin
            cnt_nxt = '0;
        end
    end

    // State and output registers; every output leaves the block from a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            phase_q <= PH_WASH;
            cnt_q   <= '0;
            cto_q   <= 1'b0;
            sto_q   <= 1'b0;
            busy    <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state   <= state_nxt;
            phase_q <= phase_nxt;
            cnt_q   <= cnt_nxt;
            cto_q   <= cto_nxt;
            sto_q   <= sto_nxt;
            busy    <= (state_nxt == EXPIRE) || is_run(state_nxt);
            fault   <= (state_nxt == FAULT);
        end
    end

    assign remaining         = cnt_q;
    assign fsm.cycle_timeout = cto_q;
    assign fsm.spin_timeout  = sto_q;

endmodule

// File: tb/tb_iiitb_wm_timer.sv
// Directed bench for iiitb_wm_timer with TICK_DIV=4, FILL_WD_TICKS=8.
// Cycle numbers in comments count posedges after the edge that starts a phase (E0).
module tb_iiitb_wm_timer;

    logic        clk;
    logic        reset;
    logic [1:0]  prog_sel;
    logic [15:0] custom_wash;
    logic [15:0] custom_spin;
    logic        pause;
    logic        fault;
    logic        busy;
    logic [15:0] remaining;

    int checks;
    int failures;

    iiitb_wm_timer_if wm_if ();

    iiitb_wm_timer #(
        .TICK_DIV      (4),
        .CNT_W         (16),
        .FILL_WD_TICKS (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .prog_sel    (prog_sel),
        .custom_wash (custom_wash),
        .custom_spin (custom_spin),
        .pause       (pause),
        .fsm         (wm_if),
        .fault       (fault),
        .busy        (busy),
        .remaining   (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        prog_sel = 2'd0;
        custom_wash = 16'd0;
        custom_spin = 16'd0;
        pause    = 1'b0;
        wm_if.door_lock      = 1'b0;
        wm_if.motor_on       = 1'b0;
        wm_if.fill_value_on  = 1'b0;
        wm_if.drain_value_on = 1'b0;
        wm_if.water_wash     = 1'b0;
        wm_if.done           = 1'b0;

        // Reset state
        #1 reset = 1'b0;
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_remaining", 32'(remaining), 0);
        check("rst_cto", 32'(wm_if.cycle_timeout), 0);
        check("rst_sto", 32'(wm_if.spin_timeout), 0);
        @(negedge clk) reset = 1'b1;
        step(2);

        // Quick wash: 60 ticks x 4 cycles, timeout one edge later
        wm_if.door_lock = 1'b1;
        step(2);
        wm_if.motor_on = 1'b1;
        step(1);                                        // E0
        check("wash_load", 32'(remaining), 60);
        check("wash_busy", 32'(busy), 1);
        step(4);                                        // E4
        check("wash_first_tick", 32'(remaining), 59);
        step(236);                                      // E240
        check("wash_e240_cto", 32'(wm_if.cycle_timeout), 0);
        check("wash_e240_busy", 32'(busy), 1);
        check("wash_e240_rem", 32'(remaining), 0);
        step(1);                                        // E241
        check("wash_e241_cto", 32'(wm_if.cycle_timeout), 1);
        check("wash_e241_sto", 32'(wm_if.spin_timeout), 0);
        step(5);
        check("wash_cto_held", 32'(wm_if.cycle_timeout), 1);
        wm_if.motor_on = 1'b0;
        step(1);
        check("wash_cto_clear", 32'(wm_if.cycle_timeout), 0);
        check("wash_idle_busy", 32'(busy), 0);

        // Latch program 3, then change inputs while locked (must be ignored)
        wm_if.door_lock = 1'b0;
        step(1);
        prog_sel    = 2'd3;
        custom_wash = 16'd0;
        custom_spin = 16'd5;
        wm_if.door_lock = 1'b1;
        step(1);
        prog_sel    = 2'd2;
        custom_spin = 16'd9;
        custom_wash = 16'd7;
        step(2);

        // Custom spin of 5 ticks
        wm_if.drain_value_on = 1'b1;
        step(1);                                        // E0
        check("spin_rem5", 32'(remaining), 5);
        check("spin_busy", 32'(busy), 1);
        step(4);
        check("spin_rem4", 32'(remaining), 4);
        step(4);
        check("spin_rem3", 32'(remaining), 3);
        step(4);
        check("spin_rem2", 32'(remaining), 2);
        step(4);
        check("spin_rem1", 32'(remaining), 1);
        step(4);                                        // E20
        check("spin_e20_rem", 32'(remaining), 0);
        check("spin_e20_sto", 32'(wm_if.spin_timeout), 0);
        step(1);                                        // E21
        check("spin_e21_sto", 32'(wm_if.spin_timeout), 1);
        check("spin_e21_cto", 32'(wm_if.cycle_timeout), 0);
        wm_if.drain_value_on = 1'b0;
        step(1);
        check("spin_sto_clear", 32'(wm_if.spin_timeout), 0);
        check("spin_idle_busy", 32'(busy), 0);

        // Custom wash of 0 is promoted to a 1-tick wash
        wm_if.motor_on = 1'b1;
        step(1);                                        // E0
        check("zero_wash_load", 32'(remaining), 1);
        step(4);                                        // E4
        check("zero_wash_e4_cto", 32'(wm_if.cycle_timeout), 0);
        check("zero_wash_e4_busy", 32'(busy), 1);
        step(1);                                        // E5
        check("zero_wash_e5_cto", 32'(wm_if.cycle_timeout), 1);
        wm_if.motor_on = 1'b0;
        step(1);

        // done reverts the latch to program 0
        wm_if.done = 1'b1;
        step(1);
        wm_if.done = 1'b0;
        step(1);

        // Pause for 10 ticks mid-wash delays expiry by 40 cycles
        wm_if.motor_on = 1'b1;
        step(1);                                        // E0
        check("pause_load_prog0", 32'(remaining), 60);
        step(10);                                       // E10
        check("pause_e10_rem", 32'(remaining), 58);
        pause = 1'b1;
        step(40);                                       // E50
        check("pause_frozen_rem", 32'(remaining), 58);
        pause = 1'b0;
        step(1);                                        // E51
        check("pause_e51_rem", 32'(remaining), 58);
        step(1);                                        // E52
        check("pause_e52_rem", 32'(remaining), 57);
        step(228);                                      // E280
        check("pause_e280_cto", 32'(wm_if.cycle_timeout), 0);
        step(1);                                        // E281
        check("pause_e281_cto", 32'(wm_if.cycle_timeout), 1);
        wm_if.motor_on = 1'b0;
        step(1);

        // Rinse (30 ticks for program 0), then asynchronous reset mid-run
        wm_if.motor_on   = 1'b1;
        wm_if.water_wash = 1'b1;
        step(1);                                        // E0
        check("rinse_load", 32'(remaining), 30);
        step(8);                                        // E8
        check("rinse_e8_rem", 32'(remaining), 28);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_rem", 32'(remaining), 0);
        check("rst_mid_cto", 32'(wm_if.cycle_timeout), 0);
        wm_if.motor_on      = 1'b0;
        wm_if.water_wash    = 1'b0;
        wm_if.fill_value_on = 1'b1;

        // Fill watchdog: 8 ticks of continuous fill from reset release
        @(negedge clk) reset = 1'b1;
        step(31);                                       // E31
        check("wd_e31_fault", 32'(fault), 0);
        step(1);                                        // E32
        check("wd_e32_fault", 32'(fault), 1);
        check("wd_busy", 32'(busy), 0);
        wm_if.motor_on = 1'b1;
        step(300);
        check("fault_no_cto", 32'(wm_if.cycle_timeout), 0);
        check("fault_no_busy", 32'(busy), 0);
        check("fault_sticky", 32'(fault), 1);
        #2 reset = 1'b0;
        #1;
        check("fault_reset_clear", 32'(fault), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iiitb_wm_timer.md
Name: iiitb_wm_timer

Overview:
- Phase timer and supervisor for the washing-machine control FSM.
- Watches the FSM's actuator outputs (motor_on, drain_value_on, fill_value_on, water_wash, door_lock, done) to tell which phase is running.
- Counts a program-dependent duration in prescaled ticks for that phase and drives the FSM's cycle_timeout and spin_timeout inputs.
- Also runs a fill watchdog that raises a sticky fault when filling never completes.

Parameters:
- TICK_DIV, 1000: clk cycles per timer tick; legal range 1 to 65535.
- CNT_W, 16: width of the duration counter and of remaining.
- FILL_WD_TICKS, 300: maximum number of ticks fill_value_on may stay high continuously.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- prog_sel  in  2  wash program: 0 quick, 1 normal, 2 heavy, 3 custom.
- custom_wash  in  CNT_W  wash duration in ticks for program 3.
- custom_spin  in  CNT_W  spin duration in ticks for program 3.
- pause  in  1  freeze all timing while high.
- door_lock  in  1  from FSM.
- motor_on  in  1  from FSM.
- fill_value_on  in  1  from FSM.
- drain_value_on  in  1  from FSM.
- water_wash  in  1  from FSM.
- done  in  1  from FSM.
- cycle_timeout  out  1  to FSM; registered.
- spin_timeout  out  1  to FSM; registered.
- fault  out  1  sticky fill-watchdog fault.
- busy  out  1  a phase timer is active.
- remaining  out  CNT_W  ticks left in the current phase.

Behaviour:
- **Reset (reset=0):**
  - State is IDLE.
  - All outputs are 0, the prescaler is 0 and the latched program is 0.
- **Registered outputs:** every output comes from a flop. The FSM's outputs depend combinationally on cycle_timeout and spin_timeout, so no combinational path from an input to an output is allowed.
- **Program latch:**
  - prog_sel, custom_wash and custom_spin are captured on the cycle where door_lock goes 0->1.
  - Changes while door_lock=1 are ignored.
- **Durations in ticks (wash / rinse / spin):**
  - Program 0: 60 / 30 / 20.
  - Program 1: 120 / 60 / 40.
  - Program 2: 240 / 90 / 60.
  - Program 3: custom_wash / custom_wash>>1 / custom_spin.
  - Any value of 0 is forced to 1.
- **Prescaler:**
  - Counts 0..TICK_DIV-1 and emits tick on the wrap.
  - It is reset to 0 on every entry to a RUN_* state or to IDLE.
  - It holds while pause=1.
- **States:**
  - IDLE:
    - If fault=0 and motor_on=1, load the counter with the wash duration when water_wash=0 (go to RUN_WASH) or the rinse duration when water_wash=1 (go to RUN_RINSE).
    - Otherwise, if fault=0 and drain_value_on=1, load the spin duration and go to RUN_SPIN.
    - motor_on takes priority over drain_value_on.
  - RUN_WASH / RUN_RINSE / RUN_SPIN:
    - Decrement remaining on each tick.
    - On the tick where remaining goes 1->0, go to EXPIRE and assert cycle_timeout (RUN_WASH, RUN_RINSE) or spin_timeout (RUN_SPIN) from the next clock edge.
    - If the phase's request (motor_on, or drain_value_on for spin) drops before expiry, go to IDLE with no timeout.
  - EXPIRE:
    - Hold the asserted timeout high until its request input is sampled 0, then clear it and go to IDLE.
    - The other timeout stays 0.
  - FAULT:
    - Entered from any state when the fill watchdog fires.
    - cycle_timeout and spin_timeout are forced to 0; fault=1 and busy=0.
    - The only exit is reset.
- **busy** = 1 in the RUN_* states and EXPIRE.
- **remaining** shows the counter in the RUN_* states and 0 elsewhere.
- **Fill watchdog:**
  - A separate counter increments on each tick while fill_value_on=1.
  - It clears when fill_value_on=0.
  - When it reaches FILL_WD_TICKS: fault=1 and the state goes to FAULT.
  - It is frozen by pause.
- **Completion:** done=1 clears the program latch to program 0 and forces IDLE (any timeout is cleared). This has priority over the RUN_* and EXPIRE transitions.
- **Door:** door_lock=0 in a RUN_* state sends the block to IDLE with no timeout.
- **Entry into RUN_SPIN:** the FSM drives drain_value_on=1 for one cycle in the drain state before spin. RUN_SPIN therefore starts one cycle early; this is accepted behaviour.
- **Simultaneous events:**
  - Expiry and a request drop on the same tick: the request drop wins (no timeout).
  - pause=1 on the expiry cycle: the tick is suppressed.

Decomposition:
- A shared package wm_pkg holds:
  - the program encodings;
  - the 4x3 duration constant table;
  - the FSM state encodings (IDLE, RUN_WASH, RUN_RINSE, RUN_SPIN, EXPIRE, FAULT).
- One sub-module is natural: wm_tick_prescaler (parameter TICK_DIV; inputs clk, reset, clear, hold; output tick).

Test Plan:
- **Quick wash:** TICK_DIV=4, prog 0 latched, motor_on=1, water_wash=0 -> cycle_timeout rises 241 cycles after RUN_WASH entry (60 ticks x 4 cycles, plus one registered cycle) and stays high until motor_on=0, then busy=0.
- **Custom spin:** prog 3 with custom_spin=5, drain_value_on=1 -> spin_timeout after 5 ticks; remaining counts 5,4,3,2,1.
- **Pause:** pause held for 10 ticks mid-wash -> expiry delayed by exactly 10 ticks and remaining frozen throughout.
- **Fill watchdog:** FILL_WD_TICKS=8 with fill_value_on held high -> fault=1 after 8 ticks; later motor_on=1 produces no timeout; reset low clears fault.
- **Reset mid-run:** assert reset in RUN_RINSE -> all outputs 0 immediately (asynchronous).
- **Program latch and zero duration:** change prog_sel while door_lock=1 -> old durations still used; custom_wash=0 gives a 1-tick wash.
